alu_result_buffer: RTL and testbench
====================================

# alu_result_buffer

Registered result buffer directly downstream of the 64-bit combinational ALU. Captures each ALU result word, upper product word, opcode and the seven status flags into a first-word-fall-through FIFO with valid/ready handshakes on both sides, decoupling the ALU from a stalling writeback consumer. It also keeps a software-clearable sticky-flag register summarising every accepted operation.

## Interface
- N, 64, datapath width; must match the ALU.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  ALU output is valid this cycle.
- in_ready  out  1  buffer can accept; equals (count != DEPTH).
- in_sel  in  6  opcode that produced the result.
- in_result  in  N  ALU result.
- in_upper  in  N  ALU upper result (high product word for opcode 2, else 0).
- in_flags  in  7  {sign, modulo, parity, negative, zero, overflow, carry}, carry at bit 0.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes the head entry.
- out_sel  out  6  head opcode.
- out_result  out  N  head result.
- out_upper  out  N  head upper result.
- out_flags  out  7  head flags, same bit order as in_flags.
- count  out  $clog2(DEPTH)+1  current occupancy.
- sticky_flags  out  7  OR of in_flags over all pushes since the last reset or clear.
- sticky_clr  in  1  clear sticky_flags.

## Operation
- Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
- Entry is {sel, result, upper, flags}, width 2N+13; stored unmodified.
- Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally. Full and empty are decided by count, not by pointer comparison.
- count update: push only → +1; pop only → −1; both → unchanged.
- Full (count == DEPTH):
  - in_ready = 0, even if a pop happens in the same cycle. There is no pass-through on full.
  - in_valid while full is legal backpressure. The upstream side holds its inputs, and nothing is dropped or overwritten.
- Empty (count == 0):
  - out_valid = 0.
  - out_* data are don't-care, but must not be X after reset; the storage array is reset to 0.
  - No bypass: a push into an empty buffer is visible on out_* the next cycle.
- Push and pop together at count between 1 and DEPTH-1: both succeed, and count is unchanged.
- Sticky flags:
  - next = (sticky_clr ? 0 : sticky_flags) | (push ? in_flags : 0).
  - When a clear and a push fall in the same cycle, the pushed flags survive.
- Handshake rules:
  - out_* are held stable while out_valid && !out_ready.
  - in_ready does not depend combinationally on out_ready.
- Reset values (rst_n low at a rising edge): count = 0, both pointers = 0, out_valid = 0, in_ready = 1, sticky_flags = 0, storage = 0.
- Reset in the middle of operation discards all entries. An in_valid asserted during reset is not accepted.

## Timing
- Latency from an accepted push to the entry on out_*: 1 cycle when the buffer was empty. Otherwise the entry waits behind the older entries in FIFO order.
- Throughput is one push and one pop per cycle in steady state.
- All outputs are taken directly from registers or from a register-indexed read mux. There are no combinational paths from in_* to out_*.
- sticky_flags and count update on the same edge as the push or pop that changes them.

## Structure
- Shared package alu_pkg holds:
  - ALU_FLAG_W = 7;
  - flag index constants FLAG_CARRY = 0 … FLAG_SIGN = 6;
  - 6-bit opcode localparams (OP_ADD = 0 … OP_GE = 34);
  - a packed entry typedef {sel, result, upper, flags}.
- One sub-module: sync_fifo_fwft, a generic WIDTH/DEPTH first-word-fall-through FIFO with count.
- alu_result_buffer instantiates sync_fifo_fwft with WIDTH = 2N+13, packs and unpacks the entry, and owns the sticky register.

## Test plan
- Reset then a single push of sel=0, result=0x5, flags=0x00:
  - out_valid rises exactly 1 cycle later with out_result=0x5;
  - pop with out_ready=1 → count returns to 0.
- DEPTH=4, out_ready=0, push 5 times in a row:
  - in_ready falls after the 4th push and count=4;
  - the 5th word is held and is accepted only after the first pop;
  - order is preserved.
- Full buffer with in_valid=1 and out_ready=1 in the same cycle:
  - the pop succeeds, the push is refused that cycle (count goes 4 → 3), and the push is accepted on the next cycle.
- Continuous push/pop at count=2 for 10 cycles with the pointers wrapping:
  - count stays 2 throughout;
  - output sequence equals input sequence, including upper=0xFFFF_FFFF_FFFF_FFFF for sel=2.
- Sticky flags:
  - push flags 0x01, then 0x02 → sticky_flags=0x03;
  - sticky_clr together with a push of 0x10 → sticky_flags=0x10;
  - sticky_clr alone → 0x00.
- rst_n low for 1 cycle while count=3:
  - count=0, out_valid=0, sticky_flags=0 on the next cycle;
  - no stale entry appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants, flag indices, opcodes and the buffered entry layout.
package alu_pkg;
  localparam int ALU_N = 64;
  localparam int ALU_FLAG_W = 7;
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEGATIVE = 3;
  localparam int FLAG_PARITY = 4;
  localparam int FLAG_MODULO = 5;
  localparam int FLAG_SIGN = 6;
  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_MUL = 6'd2;
  localparam logic [5:0] OP_GE = 6'd34;
  typedef struct packed {
    logic [5:0] sel;
    logic [ALU_N-1:0] result;
    logic [ALU_N-1:0] upper;
    logic [ALU_FLAG_W-1:0] flags;
  } alu_entry_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with occupancy count; full/empty come from count.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  assign wr_ready = count_q != CW'(DEPTH);
  assign rd_valid = count_q != '0;
  assign push = wr_valid && wr_ready;
  assign pop = rd_valid && rd_ready;
  assign rd_data = mem_q[rd_ptr_q];
  assign count = count_q;
  always_comb count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: registered FWFT buffer of ALU results plus a clearable sticky-flag summary.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int N = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [5:0]              in_sel,
  input  logic [N-1:0]            in_result,
  input  logic [N-1:0]            in_upper,
  input  logic [ALU_FLAG_W-1:0]   in_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [5:0]              out_sel,
  output logic [N-1:0]            out_result,
  output logic [N-1:0]            out_upper,
  output logic [ALU_FLAG_W-1:0]   out_flags,
  output logic [$clog2(DEPTH):0]  count,
  output logic [ALU_FLAG_W-1:0]   sticky_flags,
  input  logic                    sticky_clr
);
  localparam int W = 2 * N + 6 + ALU_FLAG_W;
  logic [W-1:0] head;
  logic [ALU_FLAG_W-1:0] sticky_q, sticky_d;
  logic push;
  sync_fifo_fwft #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(in_valid),
    .wr_ready(in_ready),
    .wr_data({in_sel, in_result, in_upper, in_flags}),
    .rd_valid(out_valid),
    .rd_ready(out_ready),
    .rd_data(head),
    .count(count)
  );
  assign {out_sel, out_result, out_upper, out_flags} = head;
  assign push = in_valid && in_ready;
  assign sticky_flags = sticky_q;
  // a clear coinciding with a push keeps the pushed flags
  always_comb sticky_d = (sticky_clr ? '0 : sticky_q) | (push ? in_flags : '0);
  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= '0;
    else sticky_q <= sticky_d;
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed self-checking bench for alu_result_buffer (N=64, DEPTH=4).
module tb_alu_result_buffer;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, sticky_clr = 0;
  logic [5:0] in_sel = 0, out_sel;
  logic [63:0] in_result = 0, in_upper = 0, out_result, out_upper;
  logic [6:0] in_flags = 0, out_flags, sticky_flags;
  logic [2:0] count;
  logic in_ready, out_valid;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  alu_result_buffer #(.N(64), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_result(in_result), .in_upper(in_upper), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_result(out_result), .out_upper(out_upper), .out_flags(out_flags),
    .count(count), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [5:0] s, input logic [63:0] r, input logic [6:0] f);
    in_valid = v;
    in_sel = s;
    in_result = r;
    in_upper = (s == 6'd2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
    in_flags = f;
  endtask
  initial begin
    step;
    step;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sticky", sticky_flags, 0);
    chk("rst_out_result_not_x", out_result, 0);
    rst_n = 1;
    // single push, visible one cycle later
    drive(1, 6'd0, 64'h5, 7'h00);
    chk("pre_push_out_valid", out_valid, 0);
    step;
    drive(0, 0, 0, 0);
    chk("single_out_valid", out_valid, 1);
    chk("single_out_result", out_result, 64'h5);
    chk("single_count", count, 1);
    out_ready = 1;
    step;
    out_ready = 0;
    chk("single_pop_count", count, 0);
    chk("single_pop_out_valid", out_valid, 0);
    // fill to DEPTH with consumer stalled
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'd1, 64'h100 + 64'(i), 7'h00);
      step;
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    drive(1, 6'd1, 64'h104, 7'h00);
    step;
    chk("full_hold_count", count, 4);
    chk("full_hold_head", out_result, 64'h100);
    // pop while full: push refused this cycle, accepted next
    out_ready = 1;
    step;
    chk("full_pop_count", count, 3);
    chk("full_pop_head", out_result, 64'h101);
    chk("full_pop_in_ready", in_ready, 1);
    out_ready = 0;
    step;
    drive(0, 0, 0, 0);
    chk("late_push_count", count, 4);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", out_result, 64'h100 + 64'(i));
      step;
    end
    out_ready = 0;
    chk("drain_count", count, 0);
    // steady stream at count=2, pointers wrap
    for (int k = 0; k < 2; k++) begin
      drive(1, (k % 2 == 0) ? 6'd2 : 6'd0, 64'h1000 + 64'(k), 7'h00);
      step;
    end
    chk("stream_prefill", count, 2);
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      chk("stream_result", out_result, 64'h1000 + 64'(k));
      chk("stream_sel", out_sel, (k % 2 == 0) ? 6'd2 : 6'd0);
      chk("stream_upper", out_upper, (k % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
      drive(1, ((k + 2) % 2 == 0) ? 6'd2 : 6'd0, 64'h1000 + 64'(k + 2), 7'h00);
      step;
      chk("stream_count", count, 2);
    end
    drive(0, 0, 0, 0);
    for (int k = 10; k < 12; k++) begin
      chk("stream_tail", out_result, 64'h1000 + 64'(k));
      step;
    end
    chk("stream_empty", count, 0);
    // sticky flags
    drive(1, 6'd0, 64'h1, 7'h01);
    step;
    chk("sticky_1", sticky_flags, 7'h01);
    chk("head_flags_1", out_flags, 7'h01);
    drive(1, 6'd0, 64'h2, 7'h02);
    step;
    chk("sticky_or", sticky_flags, 7'h03);
    chk("head_flags_2", out_flags, 7'h02);
    sticky_clr = 1;
    drive(1, 6'd0, 64'h3, 7'h10);
    step;
    chk("sticky_clr_push", sticky_flags, 7'h10);
    drive(0, 0, 0, 0);
    step;
    sticky_clr = 0;
    chk("sticky_clr_alone", sticky_flags, 7'h00);
    step;
    out_ready = 0;
    chk("sticky_drained", count, 0);
    // reset while occupied
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'd1, 64'hA0 + 64'(i), 7'h7F);
      step;
    end
    chk("pre_rst_count", count, 3);
    chk("pre_rst_sticky", sticky_flags, 7'h7F);
    rst_n = 0;
    drive(1, 6'd1, 64'hBAD, 7'h7F);
    step;
    rst_n = 1;
    drive(0, 0, 0, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sticky", sticky_flags, 0);
    step;
    chk("post_rst_no_stale", out_valid, 0);
    drive(1, 6'd0, 64'hC0, 7'h00);
    step;
    drive(0, 0, 0, 0);
    chk("post_rst_count", count, 1);
    chk("post_rst_head", out_result, 64'hC0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
